// File: rtl/audio_frame_ring.sv
// audio_frame_ring
//   Ring of BANKS frame banks (POINTS samples each) held in one block RAM.
//   Incoming samples are gathered into whole frames; the oldest complete
//   frame is streamed out on request. When no bank is free, an entire
//   incoming frame is discarded so the frame alignment is kept.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_data  input sample stream, one sample per cycle maximum
//   read_request      start streaming the oldest complete frame
//   frame_ready       a complete frame is waiting and the reader is idle
//   frames_available  complete frames not yet being read
//   out_valid/out_data/out_last  output stream, out_last on sample POINTS-1
//   overflow          one-cycle pulse per dropped frame
//   dropped_frames    saturating drop count
//
// Build option
//   FRAME_RING_DROP_COUNT_EN  when defined, dropped_frames is a 16-bit
//                             saturating counter; otherwise it is tied to 0.
module audio_frame_ring #(
  parameter int DATA_WIDTH = 24,
  parameter int POINTS     = 512,
  parameter int BANKS      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         read_request,
  output logic                         frame_ready,
  output logic [$clog2(BANKS+1)-1:0]   frames_available,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         overflow,
  output logic [15:0]                  dropped_frames
);

  localparam int AW    = $clog2(POINTS);
  localparam int BW    = $clog2(BANKS);
  localparam int CW    = $clog2(BANKS+1);
  localparam int DEPTH = POINTS * BANKS;
  localparam logic [AW-1:0] LAST_ADDR = AW'(POINTS - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);

  typedef enum logic {FILL, DROP} wr_state_t;
  typedef enum logic {IDLE, READ} rd_state_t;

  wr_state_t       wr_state_reg, wr_state_next;
  logic [BW-1:0]   wr_bank_reg, wr_bank_next;
  logic [AW-1:0]   wr_addr_reg, wr_addr_next;
  rd_state_t       rd_state_reg, rd_state_next;
  logic [BW-1:0]   rd_bank_reg, rd_bank_next;
  logic [AW-1:0]   rd_addr_reg, rd_addr_next;
  logic [CW-1:0]   full_cnt_reg, full_cnt_next;
  logic            overflow_reg, overflow_next;
  logic            wr_en, frame_done, accept, room;
  logic [CW:0]     occupied;

  // Banks in use = complete frames plus the one being streamed. The bank
  // being streamed stays occupied until the reader has left READ.
  assign occupied = {1'b0, full_cnt_reg} + {{CW{1'b0}}, (rd_state_reg == READ)};
  assign room     = occupied < (CW+1)'(BANKS);

  always_comb begin
    wr_state_next = wr_state_reg;
    wr_bank_next  = wr_bank_reg;
    wr_addr_next  = wr_addr_reg;
    overflow_next = 1'b0;
    wr_en         = 1'b0;
    frame_done    = 1'b0;
    if (in_valid) begin
      // POINTS is a power of two, so the address wraps to 0 by itself.
      wr_addr_next = wr_addr_reg + 1'b1;
      if (wr_addr_reg == '0) begin
        if (room) begin
          wr_state_next = FILL;
          wr_en         = 1'b1;
        end else begin
          wr_state_next = DROP;
          overflow_next = 1'b1;
        end
      end else begin
        wr_en = (wr_state_reg == FILL);
      end
      if (wr_en && (wr_addr_reg == LAST_ADDR)) begin
        frame_done   = 1'b1;
        wr_bank_next = (wr_bank_reg == LAST_BANK) ? '0 : wr_bank_reg + 1'b1;
      end
    end
  end

  assign frame_ready      = (full_cnt_reg != '0) && (rd_state_reg == IDLE);
  assign frames_available = full_cnt_reg;
  assign overflow         = overflow_reg;
  assign accept           = read_request && frame_ready;

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_bank_next  = rd_bank_reg;
    rd_addr_next  = rd_addr_reg;
    case (rd_state_reg)
      IDLE: begin
        if (accept) begin
          rd_state_next = READ;
          rd_addr_next  = '0;
        end
      end
      READ: begin
        rd_addr_next = rd_addr_reg + 1'b1;
        if (rd_addr_reg == LAST_ADDR) begin
          rd_state_next = IDLE;
          rd_bank_next  = (rd_bank_reg == LAST_BANK) ? '0 : rd_bank_reg + 1'b1;
        end
      end
      default: rd_state_next = IDLE;
    endcase
    // Completion and accept in one cycle cancel out.
    full_cnt_next = full_cnt_reg + CW'(frame_done) - CW'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg <= FILL;
      wr_bank_reg  <= '0;
      wr_addr_reg  <= '0;
      rd_state_reg <= IDLE;
      rd_bank_reg  <= '0;
      rd_addr_reg  <= '0;
      full_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_state_reg <= wr_state_next;
      wr_bank_reg  <= wr_bank_next;
      wr_addr_reg  <= wr_addr_next;
      rd_state_reg <= rd_state_next;
      rd_bank_reg  <= rd_bank_next;
      rd_addr_reg  <= rd_addr_next;
      full_cnt_reg <= full_cnt_next;
      overflow_reg <= overflow_next;
    end
  end

  // Frame RAM: bank index in the upper bits, sample index in the lower bits.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [BW+AW-1:0]      wr_index, rd_index;

  assign wr_index = {wr_bank_reg, wr_addr_reg};
  assign rd_index = {rd_bank_reg, rd_addr_reg};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= in_data;
    end
    rd_q <= mem[rd_index];
  end

  // Two-stage output: RAM read register, then the output register.
  logic v1_reg, l1_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      l1_reg    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      v1_reg    <= (rd_state_reg == READ);
      l1_reg    <= (rd_state_reg == READ) && (rd_addr_reg == LAST_ADDR);
      out_valid <= v1_reg;
      out_last  <= l1_reg;
      if (v1_reg) begin
        out_data <= rd_q;
      end
    end
  end

`ifdef FRAME_RING_DROP_COUNT_EN
  logic [15:0] drop_cnt_reg;

  // Counts at the same edge that raises overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (overflow_next && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign dropped_frames = drop_cnt_reg;
`else
  assign dropped_frames = '0;
`endif

endmodule

// File: tb/tb_audio_frame_ring.sv
// Bench for audio_frame_ring with POINTS=8, BANKS=3.
module tb_audio_frame_ring;
  localparam int DW = 24;
  localparam int P  = 8;
  localparam int B  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          read_request = 1'b0;
  logic          frame_ready;
  logic [1:0]    frames_available;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          overflow;
  logic [15:0]   dropped_frames;

  audio_frame_ring #(.DATA_WIDTH(DW), .POINTS(P), .BANKS(B)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .read_request(read_request), .frame_ready(frame_ready),
    .frames_available(frames_available), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .overflow(overflow),
    .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of complete unread frames, partial frame buffer,
  // and a schedule of expected output samples keyed by edge number.
  logic [DW-1:0] q[$];
  logic [DW-1:0] part[$];
  logic [DW-1:0] exp_d[int];
  bit            exp_l[int];
  int            wpos = 0;
  bit            wdrop = 0;
  int            read_left = 0;
  int            edge_n = 0;
  int            drops = 0;
  bit            exp_ovf = 0;
  int            ovf_seen = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(bit iv, logic [DW-1:0] d, bit rr, bit r);
    bit            busy, acc, done;
    int            nfull;
    logic [DW-1:0] fin[$];
    edge_n++;
    exp_ovf = 0;
    if (r) begin
      q.delete(); part.delete(); exp_d.delete(); exp_l.delete();
      wpos = 0; wdrop = 0; read_left = 0; drops = 0;
      return;
    end
    busy  = (read_left > 0);
    nfull = q.size() / P;
    acc   = rr && (nfull > 0) && !busy;
    done  = 0;
    if (iv) begin
      if (wpos == 0) begin
        if (nfull + int'(busy) < B) wdrop = 0;
        else begin
          wdrop = 1;
          exp_ovf = 1;
          if (drops < 65535) drops++;
        end
      end
      if (!wdrop) part.push_back(d);
      wpos++;
      if (wpos == P) begin
        wpos = 0;
        if (!wdrop) begin
          fin = part;
          part.delete();
          done = 1;
        end
      end
    end
    if (busy) read_left--;
    if (acc) begin
      for (int j = 0; j < P; j++) begin
        exp_d[edge_n + 2 + j] = q.pop_front();
        exp_l[edge_n + 2 + j] = (j == P - 1);
      end
      read_left = P;
    end
    if (done) begin
      foreach (fin[k]) q.push_back(fin[k]);
    end
  endtask

  task automatic check_outputs(bit r);
    bit ev;
    int exp_drop;
    ev = exp_d.exists(edge_n);
`ifdef FRAME_RING_DROP_COUNT_EN
    exp_drop = drops;
`else
    exp_drop = 0;
`endif
    chk("frame_ready", {31'd0, frame_ready}, {31'd0, (q.size() > 0) && (read_left == 0)});
    chk("frames_available", {30'd0, frames_available}, q.size() / P);
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) chk("out_data", {8'd0, out_data}, {8'd0, exp_d[edge_n]});
    else if (r) chk("out_data_rst", {8'd0, out_data}, 0);
    chk("out_last", {31'd0, out_last}, {31'd0, ev ? exp_l[edge_n] : 1'b0});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("dropped_frames", {16'd0, dropped_frames}, exp_drop);
    if (ev) begin
      exp_d.delete(edge_n);
      exp_l.delete(edge_n);
    end
  endtask

  task automatic step(bit iv, logic [DW-1:0] d, bit rr, bit r);
    in_valid = iv; in_data = d; read_request = rr; rst = r;
    @(posedge clk);
    model_edge(iv, d, rr, r);
    #1;
    check_outputs(r);
    if (overflow) ovf_seen++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  task automatic write_frame(int base);
    for (int s = 0; s < P; s++) step(1, DW'(base + s), 0, 0);
  endtask

  typedef struct {
    int nframes;
    int nreads;
    int exp_avail;
    int exp_drops;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   acc_edge, first_edge, vcnt, last_data, gaps, seen, guard;
    bit   started;

    vt[0] = '{1, 0, 1, 0};
    vt[1] = '{1, 1, 0, 0};
    vt[2] = '{3, 0, 3, 0};
    vt[3] = '{3, 3, 0, 0};
    vt[4] = '{4, 0, 3, 1};
    vt[5] = '{5, 0, 3, 2};
    vt[6] = '{2, 1, 1, 0};

    // Reset state
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Scenario table
    for (int i = 0; i < 7; i++) begin
      step(0, '0, 0, 1);
      ovf_seen = 0;
      for (int f = 0; f < vt[i].nframes; f++) write_frame(100 * i + f * P + 1);
      for (int rd = 0; rd < vt[i].nreads; rd++) begin
        step(0, '0, 1, 0);
        idle(10);
      end
      idle(2);
      chk("vec_avail", {30'd0, frames_available}, vt[i].exp_avail);
      chk("vec_overflow_pulses", ovf_seen, vt[i].exp_drops);
`ifdef FRAME_RING_DROP_COUNT_EN
      chk("vec_dropped", {16'd0, dropped_frames}, vt[i].exp_drops);
`else
      chk("vec_dropped", {16'd0, dropped_frames}, 0);
`endif
    end

    // Fill: frame 1..8, then read timing
    step(0, '0, 0, 1);
    write_frame(1);
    chk("fill_ready", {31'd0, frame_ready}, 1);
    chk("fill_avail", {30'd0, frames_available}, 1);
    step(0, '0, 1, 0);
    acc_edge = edge_n; first_edge = -1; vcnt = 0; last_data = -1;
    for (int i = 0; i < 14; i++) begin
      step(0, '0, 0, 0);
      if (out_valid) begin
        if (first_edge < 0) first_edge = edge_n;
        vcnt++;
        if (out_last) last_data = int'(out_data);
      end
    end
    chk("fill_latency", first_edge - acc_edge, 2);
    chk("fill_count", vcnt, P);
    chk("fill_last_sample", last_data, 8);

    // Queueing: three frames, back-to-back reads, one-cycle gaps
    step(0, '0, 0, 1);
    write_frame(1); write_frame(9); write_frame(17);
    chk("queue_avail", {30'd0, frames_available}, 3);
    vcnt = 0; gaps = 0; started = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, '0, 1, 0);
      if (out_valid) begin
        started = 1;
        vcnt++;
        gaps += seen;
        seen = 0;
      end else if (started) seen++;
    end
    chk("queue_samples", vcnt, 3 * P);
    chk("queue_gap_cycles", gaps, 2);

    // Overflow, then a fifth frame after one read
    step(0, '0, 0, 1);
    ovf_seen = 0;
    write_frame(1); write_frame(9); write_frame(17); write_frame(25);
    chk("ovf_pulses", ovf_seen, 1);
    step(0, '0, 1, 0);
    idle(10);
    write_frame(33);
    chk("ovf_refill_avail", {30'd0, frames_available}, 3);
    for (int i = 0; i < 40; i++) step(0, '0, 1, 0);

    // Frame completion coinciding with a read accept
    step(0, '0, 0, 1);
    write_frame(1);
    for (int s = 0; s < P - 1; s++) step(1, DW'(9 + s), 0, 0);
    step(1, DW'(16), 1, 0);
    chk("sim_avail", {30'd0, frames_available}, 1);
    idle(10);
    step(0, '0, 1, 0);
    idle(12);

    // Reset mid-read and mid-fill
    step(0, '0, 0, 1);
    write_frame(51);
    step(0, '0, 1, 0);
    vcnt = 0; guard = 0;
    while (vcnt < 4 && guard < 20) begin
      step(0, '0, 0, 0);
      if (out_valid) vcnt++;
      guard++;
    end
    chk("rst_read_reached", vcnt, 4);
    step(0, '0, 0, 1);
    chk("rst_read_out_valid", {31'd0, out_valid}, 0);
    for (int s = 0; s < 4; s++) step(1, DW'(70 + s), 0, 0);
    step(1, DW'(74), 0, 1);
    chk("rst_fill_avail", {30'd0, frames_available}, 0);
    write_frame(81);
    step(0, '0, 1, 0);
    idle(12);

    // Request with nothing to read
    step(0, '0, 0, 1);
    step(0, '0, 1, 0);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, '0, 0, 0);
      if (out_valid) vcnt++;
    end
    chk("ignored_request", vcnt, 0);

    // Random traffic
    step(0, '0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 9) < 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
